ifu_fetch_responder: RTL and testbench
======================================

Name: ifu_fetch_responder

Overview:
Responder end of the IFU instruction-fetch handshake. Accepts one PC request at a time on the pc_valid/pc_ready channel and fetches the 32-bit word over an AXI4-Lite read master (AR/R). Returns the instruction on the inst_valid/inst_ready channel, with a per-response error flag and a sticky error flag. Sits between the IFU and the memory/bus arbiter; at most one outstanding transaction.

Parameters:
ADDR_W, 32, PC / ARADDR width
INST_W, 32, instruction / RDATA width
ERR_INST, 32'h0000_0000, instruction value returned with any errored response

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-low (asserted at 0)
ARBITER_IFU_pc  in  ADDR_W  fetch address from IFU
ARBITER_IFU_pc_valid  in  1  fetch request valid
ARBITER_IFU_pc_ready  out  1  responder accepts request
ARBITER_IFU_inst  out  INST_W  fetched instruction
ARBITER_IFU_inst_valid  out  1  instruction valid
ARBITER_IFU_inst_ready  in  1  IFU accepts instruction
ARBITER_IFU_inst_err  out  1  current response is errored (qualified by inst_valid)
ARBITER_IFU_err_sticky  out  1  any errored response since reset
araddr  out  ADDR_W  AXI read address
arvalid  out  1  AXI read address valid
arready  in  1  AXI read address ready
rdata  in  INST_W  AXI read data
rresp  in  2  AXI read response
rvalid  in  1  AXI read data valid
rready  out  1  AXI read data ready

Behaviour:
- Reset (rst=0, async): state=IDLE; pc_ready=1, inst_valid=0, inst=0, inst_err=0, err_sticky=0, arvalid=0, araddr=0, rready=0. Deassertion synchronised by the integrating block; no requirement here.
- FSM states: IDLE, AR, R, RESP.
- IDLE: pc_ready=1. On pc_valid: latch pc. If pc[1:0]!=0 -> RESP with inst=ERR_INST, inst_err=1 (no bus access). Else -> AR with araddr=pc.
- AR: arvalid=1, araddr stable until arready; on arvalid&arready -> R. arvalid never drops before handshake.
- R: rready=1. On rvalid: latch rdata; inst_err = (rresp!=2'b00); if errored, inst=ERR_INST instead of rdata. -> RESP.
- RESP: inst_valid=1; inst and inst_err held stable until inst_ready. On inst_valid&inst_ready -> IDLE.
- pc_ready=1 only in IDLE; no request is accepted while a transaction is in flight (no pipelining, no back-to-back overlap).
- err_sticky set on the cycle RESP is entered with inst_err=1; cleared only by reset.
- Latency: request accepted at cycle T; arvalid at T+1; with arready at T+1 and rvalid at T+2, inst_valid at T+3. Misaligned: inst_valid at T+1.
- Simultaneous: rvalid may arrive in the same cycle arready completes only if the interconnect allows it; the responder ignores rvalid outside R (rready=0).
- inst_ready held low: responder stalls in RESP indefinitely, pc_ready stays 0.
- Reset mid-transaction: all state cleared immediately; the in-flight AXI transaction is abandoned (the interconnect is reset together).
- No flush input: IFU discards stale responses itself; the responder always completes every accepted request.

Decomposition:
- Shared package: ADDR_W/INST_W defaults, AXI RRESP encodings (OKAY=2'b00, EXOKAY, SLVERR, DECERR), FSM state enum, ERR_INST constant.
- Single module. No natural sub-module; the FSM and the registers are small enough to stay in one block.

Test Plan:
- Aligned fetch, pc=0x8000_0000, arready immediate, rvalid next cycle with rdata=0x0000_0297, rresp=0 -> araddr=0x8000_0000; inst_valid at T+3, inst=0x0000_0297, inst_err=0.
- arready delayed 4 cycles, rvalid delayed 3 cycles -> arvalid/araddr stable throughout; pc_ready=0 until response consumed; inst correct.
- rresp=2'b10 (SLVERR) with rdata=0xDEAD_BEEF -> inst=0x0000_0000, inst_err=1, err_sticky=1 and remains 1 after a later clean fetch.
- pc=0x8000_0002 -> no arvalid ever asserted; inst_valid at T+1 with inst_err=1, err_sticky=1.
- inst_ready held 0 for 5 cycles with pc_valid=1 -> inst/inst_valid stable, pc_ready=0; after inst_ready the next pc is accepted in IDLE.
- rst pulsed low while in R -> all outputs return to reset values asynchronously; next fetch after release completes normally.

Source files
------------

// File: rtl/ifu_fetch_responder_pkg.sv
// Shared types and constants for the IFU fetch responder: widths, AXI read responses, FSM states.
package ifu_fetch_responder_pkg;

    localparam int          ADDR_W_DEF   = 32;
    localparam int          INST_W_DEF   = 32;
    localparam logic [31:0] ERR_INST_DEF = 32'h0000_0000;

    localparam logic [1:0] RRESP_OKAY   = 2'b00;
    localparam logic [1:0] RRESP_EXOKAY = 2'b01;
    localparam logic [1:0] RRESP_SLVERR = 2'b10;
    localparam logic [1:0] RRESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_RESP
    } fetch_state_e;

    // Instruction fetches must be word aligned; anything else is answered locally.
    function automatic logic is_misaligned(input logic [1:0] pc_lsb);
        return pc_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/ifu_fetch_responder.sv
// One-at-a-time PC -> AXI4-Lite read -> instruction responder; aligned fetch returns 3 cycles after accept, misaligned 1.
// pc_ready is high only in IDLE; the response is held in RESP for as long as inst_ready stays low.
module ifu_fetch_responder
    import ifu_fetch_responder_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                INST_W   = INST_W_DEF,
    parameter logic [INST_W-1:0] ERR_INST = ERR_INST_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ARBITER_IFU_pc,
    input  logic              ARBITER_IFU_pc_valid,
    output logic              ARBITER_IFU_pc_ready,
    output logic [INST_W-1:0] ARBITER_IFU_inst,
    output logic              ARBITER_IFU_inst_valid,
    input  logic              ARBITER_IFU_inst_ready,
    output logic              ARBITER_IFU_inst_err,
    output logic              ARBITER_IFU_err_sticky,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [INST_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready
);

    fetch_state_e      state_q;
    logic              pc_ready_q;
    logic [INST_W-1:0] inst_q;
    logic              inst_valid_q;
    logic              inst_err_q;
    logic              err_sticky_q;
    logic [ADDR_W-1:0] araddr_q;
    logic              arvalid_q;
    logic              rready_q;

    // Every handshake output is a register so the bus and IFU see glitch-free levels.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            pc_ready_q   <= 1'b1;
            inst_q       <= '0;
            inst_valid_q <= 1'b0;
            inst_err_q   <= 1'b0;
            err_sticky_q <= 1'b0;
            araddr_q     <= '0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (ARBITER_IFU_pc_valid) begin
                        pc_ready_q <= 1'b0;
                        if (is_misaligned(ARBITER_IFU_pc[1:0])) begin
                            state_q      <= ST_RESP;
                            inst_q       <= ERR_INST;
                            inst_err_q   <= 1'b1;
                            err_sticky_q <= 1'b1;
                            inst_valid_q <= 1'b1;
                        end else begin
                            state_q   <= ST_AR;
                            araddr_q  <= ARBITER_IFU_pc;
                            arvalid_q <= 1'b1;
                        end
                    end
                end
                ST_AR: begin
                    if (arready) begin
                        state_q   <= ST_R;
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                    end
                end
                ST_R: begin
                    if (rvalid) begin
                        state_q      <= ST_RESP;
                        rready_q     <= 1'b0;
                        inst_valid_q <= 1'b1;
                        if (rresp != RRESP_OKAY) begin
                            inst_q       <= ERR_INST;
                            inst_err_q   <= 1'b1;
                            err_sticky_q <= 1'b1;
                        end else begin
                            inst_q     <= rdata;
                            inst_err_q <= 1'b0;
                        end
                    end
                end
                ST_RESP: begin
                    if (ARBITER_IFU_inst_ready) begin
                        state_q      <= ST_IDLE;
                        inst_valid_q <= 1'b0;
                        pc_ready_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    pc_ready_q   <= 1'b1;
                    inst_valid_q <= 1'b0;
                    arvalid_q    <= 1'b0;
                    rready_q     <= 1'b0;
                end
            endcase
        end
    end

    assign ARBITER_IFU_pc_ready   = pc_ready_q;
    assign ARBITER_IFU_inst       = inst_q;
    assign ARBITER_IFU_inst_valid = inst_valid_q;
    assign ARBITER_IFU_inst_err   = inst_err_q;
    assign ARBITER_IFU_err_sticky = err_sticky_q;
    assign araddr                 = araddr_q;
    assign arvalid                = arvalid_q;
    assign rready                 = rready_q;

endmodule

// File: tb/tb_ifu_fetch_responder.sv
// Directed table of fetches plus hand-written reset and stall sequences for ifu_fetch_responder.
module tb_ifu_fetch_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        pc_valid;
    logic        pc_ready;
    logic [31:0] inst;
    logic        inst_valid;
    logic        inst_ready;
    logic        inst_err;
    logic        err_sticky;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        int          ar_dly;
        int          r_dly;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        int          hold;
        logic [31:0] exp_inst;
        logic        exp_err;
        logic        exp_sticky;
        logic        exp_bus;
    } vec_t;

    vec_t vecs[7];

    ifu_fetch_responder dut (
        .clk                    (clk),
        .rst                    (rst),
        .ARBITER_IFU_pc         (pc),
        .ARBITER_IFU_pc_valid   (pc_valid),
        .ARBITER_IFU_pc_ready   (pc_ready),
        .ARBITER_IFU_inst       (inst),
        .ARBITER_IFU_inst_valid (inst_valid),
        .ARBITER_IFU_inst_ready (inst_ready),
        .ARBITER_IFU_inst_err   (inst_err),
        .ARBITER_IFU_err_sticky (err_sticky),
        .araddr                 (araddr),
        .arvalid                (arvalid),
        .arready                (arready),
        .rdata                  (rdata),
        .rresp                  (rresp),
        .rvalid                 (rvalid),
        .rready                 (rready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_pc_ready"},   pc_ready,   1);
        chk({tag, "_inst_valid"}, inst_valid, 0);
        chk({tag, "_inst"},       inst,       0);
        chk({tag, "_inst_err"},   inst_err,   0);
        chk({tag, "_err_sticky"}, err_sticky, 0);
        chk({tag, "_arvalid"},    arvalid,    0);
        chk({tag, "_araddr"},     araddr,     0);
        chk({tag, "_rready"},     rready,     0);
    endtask

    // Drives one request and acts as the AXI slave; judges latency, payload and handshake rules.
    task automatic run_fetch(input string tag, input vec_t v);
        int          got = -1;
        int          ar_cyc = 0;
        int          r_cyc = 0;
        bit          saw_ar = 0;
        bit          ar_done = 0;
        bit          bad = 0;
        bit          stall_bad = 0;
        int          exp_lat;
        logic [31:0] cap;
        exp_lat = v.exp_bus ? 3 + v.ar_dly + v.r_dly : 1;
        @(negedge clk);
        chk({tag, "_pc_ready_idle"}, pc_ready, 1);
        pc = v.pc;
        pc_valid = 1'b1;
        for (int k = 1; k <= 60 && got < 0; k++) begin
            @(negedge clk);
            pc_valid = (v.hold > 0);
            arready = 1'b0;
            rvalid = 1'b0;
            if (pc_ready) bad = 1;
            if (ar_done && arvalid) bad = 1;
            if (saw_ar && !ar_done && !arvalid) bad = 1;
            if (inst_valid) begin
                got = k;
            end else begin
                if (arvalid) begin
                    saw_ar = 1;
                    if (araddr !== v.pc) bad = 1;
                    // Spurious read data during AR must be ignored.
                    rvalid = 1'b1;
                    rdata = 32'hBAD0_BAD0;
                    rresp = 2'b11;
                    if (ar_cyc >= v.ar_dly) begin
                        arready = 1'b1;
                        ar_done = 1;
                    end
                    ar_cyc++;
                end
                if (rready) begin
                    if (r_cyc >= v.r_dly) begin
                        rvalid = 1'b1;
                        rdata = v.rdata;
                        rresp = v.rresp;
                    end
                    r_cyc++;
                end
            end
        end
        arready = 1'b0;
        rvalid = 1'b0;
        chk({tag, "_latency"},    got,        exp_lat);
        chk({tag, "_inst"},       inst,       v.exp_inst);
        chk({tag, "_inst_err"},   inst_err,   v.exp_err);
        chk({tag, "_err_sticky"}, err_sticky, v.exp_sticky);
        chk({tag, "_bus_used"},   saw_ar,     v.exp_bus);
        chk({tag, "_handshake"},  bad,        0);
        cap = inst;
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            if (!inst_valid || inst !== cap || pc_ready) stall_bad = 1;
        end
        if (v.hold > 0) chk({tag, "_stall_stable"}, stall_bad, 0);
        inst_ready = 1'b1;
        pc_valid = 1'b0;
        @(negedge clk);
        inst_ready = 1'b0;
        chk({tag, "_released"}, {inst_valid, pc_ready}, 2'b01);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t m;
        //           pc           ar r rdata         rresp hold exp_inst     err st bus
        vecs[0] = '{32'h8000_0000, 0, 0, 32'h0000_0297, 2'b00, 0, 32'h0000_0297, 0, 0, 1};
        vecs[1] = '{32'h8000_1004, 4, 3, 32'h00A0_0513, 2'b00, 0, 32'h00A0_0513, 0, 0, 1};
        vecs[2] = '{32'h8000_0010, 0, 1, 32'hDEAD_BEEF, 2'b10, 0, 32'h0000_0000, 1, 1, 1};
        vecs[3] = '{32'h8000_0020, 1, 0, 32'h1234_5678, 2'b00, 0, 32'h1234_5678, 0, 1, 1};
        vecs[4] = '{32'h8000_0002, 0, 0, 32'h0000_0000, 2'b00, 0, 32'h0000_0000, 1, 1, 0};
        vecs[5] = '{32'h8000_0030, 2, 2, 32'hFFFF_FFFF, 2'b11, 0, 32'h0000_0000, 1, 1, 1};
        vecs[6] = '{32'h8000_0050, 0, 0, 32'h0000_0073, 2'b00, 5, 32'h0000_0073, 0, 1, 1};

        rst = 1'b0;
        pc = '0;
        pc_valid = 1'b0;
        inst_ready = 1'b0;
        arready = 1'b0;
        rdata = '0;
        rresp = '0;
        rvalid = 1'b0;
        repeat (2) @(negedge clk);
        check_reset("por");
        rst = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_fetch($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset asserted while waiting for read data: outputs must clear before any clock edge.
        @(negedge clk);
        pc = 32'h8000_0060;
        pc_valid = 1'b1;
        @(negedge clk);
        pc_valid = 1'b0;
        chk("mid_arvalid", arvalid, 1);
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        chk("mid_in_r", rready, 1);
        #2 rst = 1'b0;
        #1 check_reset("mid_rst");
        @(negedge clk);
        rst = 1'b1;

        // Misaligned first after reset: sticky must come from the local error alone.
        m = '{32'h8000_0003, 0, 0, 32'h0, 2'b00, 0, 32'h0000_0000, 1, 1, 0};
        run_fetch("post_rst_misal", m);
        m = '{32'h8000_0064, 0, 0, 32'h0000_0113, 2'b00, 0, 32'h0000_0113, 0, 1, 1};
        run_fetch("post_rst_clean", m);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
